// File: rtl/adsr_pkg.sv
// Shared definitions for the AHDSR envelope generator: stage encoding and
// rate/level helper functions.
package adsr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_HOLD    = 3'd2,
    ST_DECAY   = 3'd3,
    ST_SUSTAIN = 3'd4,
    ST_RELEASE = 3'd5
  } stage_t;

  // Step threshold for a time index: (thr0+1)*2**idx - 1, idx clamped to max_idx.
  function automatic logic [63:0] thr_of(input int unsigned idx,
                                         input int unsigned max_idx,
                                         input int unsigned thr0);
    int unsigned i;
    i = (idx > max_idx) ? max_idx : idx;
    return ((64'(thr0) + 64'd1) << i) - 64'd1;
  endfunction

  function automatic int unsigned lmax_of(input int unsigned nbit);
    return 32'((64'd1 << nbit) - 64'd1);
  endfunction

endpackage

// File: rtl/adsr_rate_div.sv
// Step counter: counts 0..thr and pulses step_tc while at thr, then wraps.
module adsr_rate_div #(
  parameter int unsigned CNT_W = 28
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic [CNT_W-1:0] thr,
  output logic             step_tc
);

  logic [CNT_W-1:0] cnt;

  // >= so a live drop of thr below the current count still wraps promptly
  assign step_tc = (cnt >= thr);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr || step_tc) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/adsr_env_gen.sv
// AHDSR envelope generator for one voice: stage FSM, level register and
// per-stage rate selection driving a shared step counter.
module adsr_env_gen
  import adsr_pkg::*;
#(
  parameter int unsigned NBIT_DATA = 8,
  parameter int unsigned NBIT_IDX  = 4,
  parameter int unsigned MAX_IDX   = 14,
  parameter int unsigned CNT_W     = 28,
  parameter int unsigned STEP_THR0 = 190
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 vin,
  input  logic                 retrig_mode,
  input  logic [NBIT_IDX-1:0]  a_t_idx,
  input  logic [NBIT_IDX-1:0]  h_t_idx,
  input  logic [NBIT_IDX-1:0]  d_t_idx,
  input  logic [NBIT_DATA-1:0] s_level,
  input  logic [NBIT_IDX-1:0]  r_t_idx,
  output logic [NBIT_DATA-1:0] dout,
  output logic                 dout_upd,
  output logic                 vout,
  output logic [2:0]           stage
);

  localparam logic [NBIT_DATA-1:0] LMAX = NBIT_DATA'(lmax_of(NBIT_DATA));
  localparam logic [NBIT_DATA-1:0] ONE  = NBIT_DATA'(1);

  stage_t               st_q, st_d;
  logic [NBIT_DATA-1:0] lvl_d;
  logic [NBIT_IDX-1:0]  idx_sel;
  logic [CNT_W-1:0]     thr;
  logic                 step_tc;
  logic                 clr;

  always_comb begin
    idx_sel = a_t_idx;
    case (st_q)
      ST_HOLD:               idx_sel = h_t_idx;
      ST_DECAY, ST_SUSTAIN:  idx_sel = d_t_idx;
      ST_RELEASE:            idx_sel = r_t_idx;
      default:               idx_sel = a_t_idx;
    endcase
  end

  assign thr = CNT_W'(thr_of(32'(idx_sel), MAX_IDX, STEP_THR0));
  assign clr = (st_d != st_q);

  adsr_rate_div #(.CNT_W(CNT_W)) u_rate_div (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (clr),
    .thr     (thr),
    .step_tc (step_tc)
  );

  always_comb begin
    st_d  = st_q;
    lvl_d = dout;
    case (st_q)
      ST_IDLE: if (vin) st_d = ST_ATTACK;
      ST_ATTACK: begin
        if (!vin)              st_d = ST_RELEASE;
        else if (dout == LMAX) st_d = ST_HOLD;
        else if (step_tc) begin
          lvl_d = dout + ONE;
          if (lvl_d == LMAX) st_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!vin)         st_d = ST_RELEASE;
        else if (step_tc) st_d = ST_DECAY;
      end
      ST_DECAY: begin
        if (!vin)                  st_d  = ST_RELEASE;
        else if (dout <= s_level)  st_d  = ST_SUSTAIN;
        else if (step_tc)          lvl_d = dout - ONE;
      end
      ST_SUSTAIN: begin
        if (!vin)                             st_d  = ST_RELEASE;
        else if (step_tc && dout < s_level)   lvl_d = dout + ONE;
        else if (step_tc && dout > s_level)   lvl_d = dout - ONE;
      end
      ST_RELEASE: begin
        if (vin) begin
          st_d = ST_ATTACK;
          if (!retrig_mode) lvl_d = '0;
        end
        else if (dout == '0) st_d  = ST_IDLE;
        else if (step_tc)    lvl_d = dout - ONE;
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q     <= ST_IDLE;
      dout     <= '0;
      dout_upd <= 1'b0;
    end else begin
      st_q     <= st_d;
      dout     <= lvl_d;
      dout_upd <= (lvl_d != dout);
    end
  end

  assign stage = st_q;
  assign vout  = (st_q != ST_IDLE);

endmodule
